// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// Moore strobes are registered from the next state so they line up with `state`; Aload/PCload add the Mealy terms.
module control_unit (
    input  logic       clk,
    input  logic       clear,
    input  logic [2:0] IR75,
    input  logic       Aeq0,
    input  logic       Apos,
    input  logic       enter,
    output logic       IRload,
    output logic       JMPmux,
    output logic       PCload,
    output logic       Meminst,
    output logic       MemWr,
    output logic [1:0] Asel,
    output logic       Aload,
    output logic       Sub,
    output logic       halt,
    output logic [3:0] state
);

    // state   | meaning
    // START   | one idle cycle after clear
    // FETCH   | IR <- RAM[PC], PC <- PC+1
    // DECODE  | operand address presented to RAM
    // LOAD    | A <- RAM[IR[4:0]]
    // STORE   | RAM[IR[4:0]] <- A
    // ADD/SUB | A <- A +/- RAM[IR[4:0]]
    // INPUT   | wait for enter, A <- in
    // JZ/JPOS | PC <- IR[4:0] when condition holds
    // HALT    | stopped until clear
    typedef enum logic [3:0] {
        S_START  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD   = 4'd3,
        S_STORE  = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_INPUT  = 4'd7,
        S_JZ     = 4'd8,
        S_JPOS   = 4'd9,
        S_HALT   = 4'd10
    } state_t;

    typedef struct packed {
        logic       irload;
        logic       jmpmux;
        logic       pcload;
        logic       meminst;
        logic       memwr;
        logic [1:0] asel;
        logic       aload;
        logic       sub;
        logic       halt;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    state_t cur_state;
    state_t nxt_state;
    ctrl_t  ctrl_q;

    function automatic ctrl_t moore_ctrl(input state_t s);
        ctrl_t c;
        c = CTRL_IDLE;
        case (s)
            S_FETCH: begin
                c.irload = 1'b1;
                c.pcload = 1'b1;
            end
            S_DECODE: c.meminst = 1'b1;
            S_LOAD: begin
                c.meminst = 1'b1;
                c.asel    = 2'b10;
                c.aload   = 1'b1;
            end
            S_STORE: begin
                c.meminst = 1'b1;
                c.memwr   = 1'b1;
            end
            S_ADD: begin
                c.meminst = 1'b1;
                c.aload   = 1'b1;
            end
            S_SUB: begin
                c.meminst = 1'b1;
                c.aload   = 1'b1;
                c.sub     = 1'b1;
            end
            S_INPUT: c.asel   = 2'b01;
            S_JZ:    c.jmpmux = 1'b1;
            S_JPOS:  c.jmpmux = 1'b1;
            S_HALT:  c.halt   = 1'b1;
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    always_comb begin
        nxt_state = S_START;
        case (cur_state)
            S_START:  nxt_state = S_FETCH;
            S_FETCH:  nxt_state = S_DECODE;
            S_DECODE: begin
                case (IR75)
                    3'b000:  nxt_state = S_LOAD;
                    3'b001:  nxt_state = S_STORE;
                    3'b010:  nxt_state = S_ADD;
                    3'b011:  nxt_state = S_SUB;
                    3'b100:  nxt_state = S_INPUT;
                    3'b101:  nxt_state = S_JZ;
                    3'b110:  nxt_state = S_JPOS;
                    default: nxt_state = S_HALT;
                endcase
            end
            S_LOAD, S_STORE, S_ADD, S_SUB, S_JZ, S_JPOS: nxt_state = S_FETCH;
            S_INPUT:  nxt_state = enter ? S_FETCH : S_INPUT;
            S_HALT:   nxt_state = S_HALT;
            default:  nxt_state = S_START;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            cur_state <= S_START;
            ctrl_q    <= CTRL_IDLE;
        end else begin
            cur_state <= nxt_state;
            ctrl_q    <= moore_ctrl(nxt_state);
        end
    end

    assign IRload  = ctrl_q.irload;
    assign JMPmux  = ctrl_q.jmpmux;
    assign Meminst = ctrl_q.meminst;
    assign MemWr   = ctrl_q.memwr;
    assign Asel    = ctrl_q.asel;
    assign Sub     = ctrl_q.sub;
    assign halt    = ctrl_q.halt;
    assign state   = cur_state;

    // Condition flags and enter are used in the execute cycle itself, not a cycle late.
    assign Aload  = ctrl_q.aload
                  | ((cur_state == S_INPUT) & enter);
    assign PCload = ctrl_q.pcload
                  | ((cur_state == S_JZ)   & Aeq0)
                  | ((cur_state == S_JPOS) & Apos);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: reset, each instruction class, enter handshake, halt and mid-instruction clear.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       clear;
    logic [2:0] IR75;
    logic       Aeq0;
    logic       Apos;
    logic       enter;
    logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, halt;
    logic [1:0] Asel;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    // {IRload, JMPmux, PCload, Meminst, MemWr, Asel[1:0], Aload, Sub, halt}
    localparam logic [9:0] V_ZERO   = 10'b0000000000;
    localparam logic [9:0] V_FETCH  = 10'b1010000000;
    localparam logic [9:0] V_DECODE = 10'b0001000000;
    localparam logic [9:0] V_LOAD   = 10'b0001010100;
    localparam logic [9:0] V_STORE  = 10'b0001100000;
    localparam logic [9:0] V_ADD    = 10'b0001000100;
    localparam logic [9:0] V_SUB    = 10'b0001000110;
    localparam logic [9:0] V_IN_W   = 10'b0000001000;
    localparam logic [9:0] V_IN_GO  = 10'b0000001100;
    localparam logic [9:0] V_JMP_T  = 10'b0110000000;
    localparam logic [9:0] V_JMP_N  = 10'b0100000000;
    localparam logic [9:0] V_HALT   = 10'b0000000001;

    control_unit dut (
        .clk     (clk),
        .clear   (clear),
        .IR75    (IR75),
        .Aeq0    (Aeq0),
        .Apos    (Apos),
        .enter   (enter),
        .IRload  (IRload),
        .JMPmux  (JMPmux),
        .PCload  (PCload),
        .Meminst (Meminst),
        .MemWr   (MemWr),
        .Asel    (Asel),
        .Aload   (Aload),
        .Sub     (Sub),
        .halt    (halt),
        .state   (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_state, input logic [9:0] exp_vec);
        logic [9:0] obs;
        obs = {IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub, halt};
        tests++;
        assert (state === exp_state) else begin
            fails++;
            $error("FAIL %s state: observed %0d expected %0d", tag, state, exp_state);
        end
        tests++;
        assert (obs === exp_vec) else begin
            fails++;
            $error("FAIL %s outputs: observed %b expected %b", tag, obs, exp_vec);
        end
    endtask

    // Starts in FETCH, leaves the DUT in the following FETCH.
    task automatic instr(input string tag, input logic [2:0] op, input logic [3:0] exe_state, input logic [9:0] exe_vec);
        IR75 = op;
        tick();
        chk({tag, "_decode"}, 4'd2, V_DECODE);
        tick();
        chk({tag, "_exec"}, exe_state, exe_vec);
        tick();
        chk({tag, "_refetch"}, 4'd1, V_FETCH);
    endtask

    initial begin
        clear = 1'b1;
        IR75  = 3'b001;
        Aeq0  = 1'b0;
        Apos  = 1'b0;
        enter = 1'b1;
        tick();
        chk("reset_1", 4'd0, V_ZERO);
        tick();
        chk("reset_2", 4'd0, V_ZERO);

        clear = 1'b0;
        enter = 1'b0;
        tick();
        chk("first_fetch", 4'd1, V_FETCH);

        instr("load",  3'b000, 4'd3, V_LOAD);
        instr("add",   3'b010, 4'd5, V_ADD);
        instr("sub",   3'b011, 4'd6, V_SUB);
        instr("store", 3'b001, 4'd4, V_STORE);

        Aeq0 = 1'b1; Apos = 1'b0;
        instr("jz_taken", 3'b101, 4'd8, V_JMP_T);
        Aeq0 = 1'b0; Apos = 1'b1;
        instr("jz_not", 3'b101, 4'd8, V_JMP_N);
        Aeq0 = 1'b0; Apos = 1'b1;
        instr("jpos_taken", 3'b110, 4'd9, V_JMP_T);
        Aeq0 = 1'b1; Apos = 1'b0;
        instr("jpos_not", 3'b110, 4'd9, V_JMP_N);
        Aeq0 = 1'b0;

        IR75 = 3'b100;
        tick();
        chk("in_decode", 4'd2, V_DECODE);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("in_wait", 4'd7, V_IN_W);
        end
        enter = 1'b1;
        #1;
        chk("in_go", 4'd7, V_IN_GO);
        tick();
        chk("in_refetch", 4'd1, V_FETCH);

        // enter left high: the next IN takes exactly one cycle of it
        instr("in_held", 3'b100, 4'd7, V_IN_GO);
        enter = 1'b0;

        IR75 = 3'b001;
        tick();
        chk("st_decode", 4'd2, V_DECODE);
        tick();
        chk("st_exec", 4'd4, V_STORE);
        clear = 1'b1;
        tick();
        chk("st_cleared", 4'd0, V_ZERO);
        clear = 1'b0;
        tick();
        chk("st_no_resume", 4'd1, V_FETCH);

        IR75 = 3'b100;
        tick();
        chk("in2_decode", 4'd2, V_DECODE);
        tick();
        chk("in2_wait", 4'd7, V_IN_W);
        clear = 1'b1;
        tick();
        chk("in2_cleared", 4'd0, V_ZERO);
        clear = 1'b0;
        tick();
        chk("in2_fetch", 4'd1, V_FETCH);

        IR75 = 3'b111;
        tick();
        chk("halt_decode", 4'd2, V_DECODE);
        tick();
        chk("halt_enter", 4'd10, V_HALT);
        for (int i = 0; i < 19; i++) begin
            IR75  = 3'(i);
            enter = i[0];
            Aeq0  = i[1];
            Apos  = i[2];
            tick();
            chk("halt_hold", 4'd10, V_HALT);
        end
        clear = 1'b1;
        tick();
        chk("halt_cleared", 4'd0, V_ZERO);
        clear = 1'b0;
        enter = 1'b0;
        tick();
        chk("halt_restart", 4'd1, V_FETCH);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
